mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 multiplier and restoring divider.
// A start is accepted in IDLE or DONE when exactly one of ctrl_MULT/ctrl_DIV
// is high. Both operations take 32 bit-iterations plus one finalize cycle, so
// data_resultRDY pulses 33 cycles after the start edge.
// Compile-time option: define MULT_DIV_DIVIDE_EN to build the divider
// datapath. Without it, a divide start finishes two cycles later with
// data_result = 0 and data_exception = 1.
module mult_div_unit #(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  // The counter reaches LAST after the final bit-iteration; the next cycle
  // finalizes the result.
  localparam logic [5:0] LAST = 6'(WIDTH);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // {upper, lower} shift register
  logic [WIDTH-1:0]     mag_q, mag_d;   // |multiplicand| or |divisor|
  logic                 neg_q, neg_d;   // result sign
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, busy_q;

  logic                 start_mult, start_div;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
`ifdef MULT_DIV_DIVIDE_EN
  logic                 bzero_q, bzero_d;
  logic [2*WIDTH-1:0]   shifted;
  logic [WIDTH:0]       trial;
`endif

  assign start_mult = ctrl_MULT & ~ctrl_DIV;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;
  assign abs_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Next-state, operand capture and one iteration of the active algorithm.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    prod     = neg_q ? -acc_q : acc_q;
`ifdef MULT_DIV_DIVIDE_EN
    bzero_d  = bzero_q;
    shifted  = {acc_q[2*WIDTH-2:0], 1'b0};
    trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, mag_q};
`endif

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start_mult) begin
          state_d = MULT;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          mag_d   = abs_a;
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else if (start_div) begin
          state_d = DIV;
`ifdef MULT_DIV_DIVIDE_EN
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, abs_a};
          mag_d   = abs_b;
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          bzero_d = (data_operandB == '0);
`else
          // Short stub: one counting cycle, then finalize.
          cnt_d   = LAST - 6'd1;
`endif
        end
      end

      // Shift-add on magnitudes: add the multiplicand into the upper half
      // when the current multiplier bit is set, then shift right with carry.
      MULT: begin
        if (cnt_q != LAST) begin
          acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = prod[WIDTH-1:0];
          exc_d    = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
          state_d  = DONE;
        end
      end

      DIV: begin
        if (cnt_q != LAST) begin
`ifdef MULT_DIV_DIVIDE_EN
          // Restoring step: keep the subtraction only when it does not borrow.
          acc_d = trial[WIDTH] ? shifted
                               : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
`endif
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d = DONE;
`ifdef MULT_DIV_DIVIDE_EN
          if (bzero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            // A positive quotient of 2^31 only arises from MIN / -1.
            exc_d    = ~neg_q & acc_q[WIDTH-1];
          end
`else
          result_d = '0;
          exc_d    = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef MULT_DIV_DIVIDE_EN
  // Divide-by-zero flag captured with the operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bzero_q <= 1'b0;
    else       bzero_q <= bzero_d;
  end
`endif

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
